// File: rtl/woi_pkg.sv
// Shared types and defaults for the window-of-interest packer and its
// detector wrapper.
//   WOI_DATA_W     : default pixel width
//   WOI_DATA_DELAY : default detector pipeline depth (pixel re-alignment)
//   woi_state_e    : packer frame state
//   fifo_entry_t   : {sow, eol, data} FIFO word at the default pixel width
package woi_pkg;

  localparam int WOI_DATA_W     = 24;
  localparam int WOI_DATA_DELAY = 2;

  typedef enum logic [1:0] {
    WAIT_SOW = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } woi_state_e;

  typedef struct packed {
    logic                  sow;
    logic                  eol;
    logic [WOI_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/woi_sync_fifo.sv
// Generic single-clock FIFO, read data presented at the read pointer.
//   clk, rst      : clock, synchronous active-high reset (flushes pointers)
//   push_i/wdata_i: write request; ignored while full (no write-through)
//   pop_i         : read request; ignored while empty
//   rdata_o       : word at read pointer, forced to 0 while empty
//   full_o/empty_o: status from current pointers only
// DEPTH must be a power of two, >= 4.
module woi_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the addresses match.
  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/woi_axis_packer.sv
// Packs in-window pixels from the window-of-interest detector into an
// AXI4-Stream master with frame-level drop on overflow.
//   clk, rst            : clock, synchronous active-high reset
//   video_data          : raw pixel, timed like the detector's inputs
//   window_enable/eol/sow: detector strobes (already DATA_DELAY late)
//   m_axis_*            : AXI4-Stream master; tuser = start of window,
//                         tlast = end of window line
//   overflow            : sticky, set on any drop
//   drop_pulse          : one cycle per discarded in-window pixel
// Optional: define WOI_AXIS_STATS_EN to add frame_cnt / dropped_frames.
module woi_axis_packer
  import woi_pkg::*;
#(
  parameter int DATA_W     = WOI_DATA_W,
  parameter int DATA_DELAY = WOI_DATA_DELAY,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] video_data,
  input  logic              window_enable,
  input  logic              eol,
  input  logic              sow,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              overflow,
  output logic              drop_pulse
`ifdef WOI_AXIS_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       dropped_frames
`endif
);

  // Same layout as fifo_entry_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic              sow;
    logic              eol;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] pix_d;
  entry_t            wr_entry, rd_entry;
  logic              full, empty, push, drop;
  logic              overflow_q, drop_q;
  woi_state_e        state_q, state_d;

  // ---- pixel re-alignment to the detector strobes ----
  generate
    if (DATA_DELAY == 0) begin : g_nodly
      assign pix_d = video_data;
    end else begin : g_dly
      logic [DATA_DELAY-1:0][DATA_W-1:0] dly_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= video_data;
          for (int i = 1; i < DATA_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign pix_d = dly_q[DATA_DELAY-1];
    end
  endgenerate

  // ---- frame state machine ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SOW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      PASS: begin
        // A back-to-back sow is just another write while in PASS.
        if (window_enable) begin
          if (!full) begin
            push = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = DROP;
          end
        end
      end
      default: begin
        // WAIT_SOW and DROP resynchronise identically on a new frame; a
        // frame whose sow cannot be stored is abandoned back in WAIT_SOW.
        if (window_enable && sow) begin
          if (!full) begin
            push    = 1'b1;
            state_d = PASS;
          end else begin
            drop    = 1'b1;
            state_d = WAIT_SOW;
          end
        end else if (window_enable && state_q == DROP) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  // ---- FIFO ----
  assign wr_entry = {sow, eol, pix_d};

  woi_sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (m_axis_tvalid & m_axis_tready),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = rd_entry.data;
  assign m_axis_tuser  = rd_entry.sow;
  assign m_axis_tlast  = rd_entry.eol;

  // ---- drop reporting, registered so it lines up with the output beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_q | drop;
      drop_q     <= drop;
    end
  end

  assign overflow   = overflow_q;
  assign drop_pulse = drop_q;

`ifdef WOI_AXIS_STATS_EN
  // A frame is lost either when PASS first drops, or when its sow is refused.
  logic        drop_frame;
  logic [15:0] frame_cnt_q, dropped_q;

  assign drop_frame = drop & ((state_q == PASS) | sow);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      dropped_q   <= '0;
    end else begin
      if (push && sow) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_frame)  dropped_q   <= dropped_q + 16'd1;
    end
  end

  assign frame_cnt      = frame_cnt_q;
  assign dropped_frames = dropped_q;
`endif

endmodule

// File: tb/tb_woi_axis_packer.sv
// Directed bench for woi_axis_packer: u0 has the default 64-entry FIFO,
// u1 a 4-entry FIFO for overflow scenarios. Both share strobes and data.
module tb_woi_axis_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] video_data;
  logic        window_enable, eol, sow;
  logic        tready0, tready1;
  logic [23:0] tdata0, tdata1;
  logic        tvalid0, tuser0, tlast0, ovf0, drop0;
  logic        tvalid1, tuser1, tlast1, ovf1, drop1;
`ifdef WOI_AXIS_STATS_EN
  logic [15:0] fc0, df0, fc1, df1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  woi_axis_packer #(.DATA_W(24), .DATA_DELAY(2), .FIFO_DEPTH(64)) u0 (
    .clk(clk), .rst(rst), .video_data(video_data), .window_enable(window_enable),
    .eol(eol), .sow(sow), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
    .m_axis_tready(tready0), .m_axis_tuser(tuser0), .m_axis_tlast(tlast0),
    .overflow(ovf0), .drop_pulse(drop0)
`ifdef WOI_AXIS_STATS_EN
    , .frame_cnt(fc0), .dropped_frames(df0)
`endif
  );

  woi_axis_packer #(.DATA_W(24), .DATA_DELAY(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .video_data(video_data), .window_enable(window_enable),
    .eol(eol), .sow(sow), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready1), .m_axis_tuser(tuser1), .m_axis_tlast(tlast1),
    .overflow(ovf1), .drop_pulse(drop1)
`ifdef WOI_AXIS_STATS_EN
    , .frame_cnt(fc1), .dropped_frames(df1)
`endif
  );

  // One clock; video_data is a free-running count, so the pixel paired with
  // a strobe driven now is video_data - 2.
  task automatic step();
    @(posedge clk); #1;
    video_data = video_data + 24'd1;
  endtask

  task automatic strobe(input logic we, input logic s, input logic e);
    window_enable = we; sow = s; eol = e;
  endtask

  task automatic idle(input int n);
    strobe(0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tready0 = 1'b0; tready1 = 1'b0;
    strobe(1, 1, 1);
    step(); step();
    checks++; if (tvalid0 !== 1'b0 || tdata0 !== 24'd0 || tuser0 !== 1'b0 || tlast0 !== 1'b0)
      begin failures++; $display("FAIL reset_axis0 valid=%b data=%h user=%b last=%b want all 0", tvalid0, tdata0, tuser0, tlast0); end
    checks++; if (ovf0 !== 1'b0 || drop0 !== 1'b0 || tvalid1 !== 1'b0 || ovf1 !== 1'b0 || drop1 !== 1'b0)
      begin failures++; $display("FAIL reset_flags ovf0=%b drop0=%b valid1=%b ovf1=%b drop1=%b want 0", ovf0, drop0, tvalid1, ovf1, drop1); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_basic();
    logic [23:0] e;
    logic        u, l;
    tready0 = 1'b1; tready1 = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 4; i++) begin
        u = (ln == 0 && i == 0); l = (i == 3);
        strobe(1, u, l); e = video_data - 24'd2;
        step();
        checks++; if (tvalid0 !== 1'b1 || tdata0 !== e || tuser0 !== u || tlast0 !== l)
          begin failures++; $display("FAIL basic_beat%0d got v=%b d=%h u=%b l=%b want 1 %h %b %b", ln*4+i, tvalid0, tdata0, tuser0, tlast0, e, u, l); end
      end
      idle(2);
      checks++; if (tvalid0 !== 1'b0)
        begin failures++; $display("FAIL basic_gap%0d tvalid=%b want 0", ln, tvalid0); end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] q [8];
    tready0 = 1'b0; tready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(1, i == 0, i == 7); q[i] = video_data - 24'd2;
      step();
    end
    idle(2);
    checks++; if (tvalid0 !== 1'b1 || tdata0 !== q[0] || tuser0 !== 1'b1 || tlast0 !== 1'b0 || drop0 !== 1'b0 || ovf0 !== 1'b0)
      begin failures++; $display("FAIL bp_stall v=%b d=%h u=%b l=%b drop=%b ovf=%b want 1 %h 1 0 0 0", tvalid0, tdata0, tuser0, tlast0, drop0, ovf0, q[0]); end
    tready0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (tvalid0 !== 1'b1 || tdata0 !== q[k] || tuser0 !== (k == 0) || tlast0 !== (k == 7))
        begin failures++; $display("FAIL bp_beat%0d got v=%b d=%h u=%b l=%b want 1 %h %b %b", k, tvalid0, tdata0, tuser0, tlast0, q[k], k == 0, k == 7); end
      step();
    end
    checks++; if (tvalid0 !== 1'b0)
      begin failures++; $display("FAIL bp_drained tvalid=%b want 0", tvalid0); end
  endtask

  task automatic test_overflow();
    logic [23:0] q [4];
    tready0 = 1'b1; tready1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(1, i == 0, i == 5);
      if (i < 4) q[i] = video_data - 24'd2;
      step();
      checks++; if (drop1 !== (i >= 4) || ovf1 !== (i >= 4))
        begin failures++; $display("FAIL ovf_pix%0d drop=%b ovf=%b want %b %b", i + 1, drop1, ovf1, i >= 4, i >= 4); end
    end
    // In DROP any further in-window pixel is discarded.
    strobe(1, 0, 0); step();
    checks++; if (drop1 !== 1'b1)
      begin failures++; $display("FAIL ovf_drop_state drop=%b want 1", drop1); end
    idle(1);
    checks++; if (drop1 !== 1'b0 || tvalid1 !== 1'b1)
      begin failures++; $display("FAIL ovf_quiet drop=%b valid=%b want 0 1", drop1, tvalid1); end
    tready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (tvalid1 !== 1'b1 || tdata1 !== q[k] || tuser1 !== (k == 0) || tlast1 !== 1'b0)
        begin failures++; $display("FAIL ovf_beat%0d got v=%b d=%h u=%b l=%b want 1 %h %b 0", k, tvalid1, tdata1, tuser1, tlast1, q[k], k == 0); end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (tvalid1 !== 1'b0)
        begin failures++; $display("FAIL ovf_after%0d tvalid=%b want 0", k, tvalid1); end
      step();
    end
  endtask

  task automatic test_recovery();
    logic [23:0] e;
    tready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(1, i == 0, i == 3); e = video_data - 24'd2;
      step();
      checks++; if (tvalid1 !== 1'b1 || tdata1 !== e || tuser1 !== (i == 0) || tlast1 !== (i == 3) || ovf1 !== 1'b1)
        begin failures++; $display("FAIL rec_beat%0d got v=%b d=%h u=%b l=%b ovf=%b want 1 %h %b %b 1", i, tvalid1, tdata1, tuser1, tlast1, ovf1, e, i == 0, i == 3); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [23:0] e;
    tready0 = 1'b0; tready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(1, i == 0, 0); step();
    end
    checks++; if (tvalid0 !== 1'b1 || tvalid1 !== 1'b1)
      begin failures++; $display("FAIL rmid_pre valid0=%b valid1=%b want 1 1", tvalid0, tvalid1); end
    rst = 1'b1; strobe(1, 0, 0); step(); rst = 1'b0;
    checks++; if (tvalid0 !== 1'b0 || tvalid1 !== 1'b0 || ovf0 !== 1'b0 || ovf1 !== 1'b0)
      begin failures++; $display("FAIL rmid_flush valid0=%b valid1=%b ovf0=%b ovf1=%b want 0", tvalid0, tvalid1, ovf0, ovf1); end
    for (int i = 4; i < 8; i++) begin
      strobe(1, 0, i == 7); step();
      checks++; if (tvalid0 !== 1'b0 || tvalid1 !== 1'b0 || drop1 !== 1'b0)
        begin failures++; $display("FAIL rmid_ignore%0d valid0=%b valid1=%b drop1=%b want 0", i, tvalid0, tvalid1, drop1); end
    end
    tready0 = 1'b1; tready1 = 1'b1;
    idle(2);
    for (int i = 0; i < 2; i++) begin
      strobe(1, i == 0, i == 1); e = video_data - 24'd2;
      step();
      checks++; if (tvalid0 !== 1'b1 || tdata0 !== e || tuser0 !== (i == 0) || tlast0 !== (i == 1))
        begin failures++; $display("FAIL rmid_beat%0d got v=%b d=%h u=%b l=%b want 1 %h %b %b", i, tvalid0, tdata0, tuser0, tlast0, e, i == 0, i == 1); end
    end
    idle(2);
  endtask

  // Full FIFO with a pop in the same cycle still refuses the write.
  task automatic test_full_pop();
    logic [23:0] q [4];
    tready0 = 1'b1; tready1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(1, i == 0, 0); q[i] = video_data - 24'd2; step();
    end
    tready1 = 1'b1;
    strobe(1, 0, 0); step();
    checks++; if (drop1 !== 1'b1 || tdata1 !== q[1])
      begin failures++; $display("FAIL fullpop_drop drop=%b d=%h want 1 %h", drop1, tdata1, q[1]); end
    strobe(1, 0, 0); step();
    checks++; if (drop1 !== 1'b1 || tdata1 !== q[2])
      begin failures++; $display("FAIL fullpop_dropstate drop=%b d=%h want 1 %h", drop1, tdata1, q[2]); end
    idle(1);
    checks++; if (drop1 !== 1'b0 || tvalid1 !== 1'b1 || tdata1 !== q[3])
      begin failures++; $display("FAIL fullpop_last drop=%b v=%b d=%h want 0 1 %h", drop1, tvalid1, tdata1, q[3]); end
    idle(1);
    checks++; if (tvalid1 !== 1'b0)
      begin failures++; $display("FAIL fullpop_empty tvalid=%b want 0", tvalid1); end
  endtask

`ifdef WOI_AXIS_STATS_EN
  task automatic test_stats();
    rst = 1'b1; step(); rst = 1'b0;
    tready0 = 1'b1; tready1 = 1'b1;
    idle(3);
    for (int i = 0; i < 2; i++) begin strobe(1, i == 0, i == 1); step(); end
    idle(2);
    tready1 = 1'b0;
    for (int i = 0; i < 6; i++) begin strobe(1, i == 0, i == 5); step(); end
    idle(1); tready1 = 1'b1; idle(6);
    for (int i = 0; i < 2; i++) begin strobe(1, i == 0, i == 1); step(); end
    idle(2);
    checks++; if (fc1 !== 16'd3 || df1 !== 16'd1)
      begin failures++; $display("FAIL stats_u1 frame_cnt=%0d dropped=%0d want 3 1", fc1, df1); end
    checks++; if (fc0 !== 16'd3 || df0 !== 16'd0)
      begin failures++; $display("FAIL stats_u0 frame_cnt=%0d dropped=%0d want 3 0", fc0, df0); end
  endtask
`endif

  initial begin
    rst = 1'b1; video_data = '0;
    window_enable = 1'b0; eol = 1'b0; sow = 1'b0;
    tready0 = 1'b0; tready1 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_recovery();
    test_reset_mid();
    test_full_pop();
`ifdef WOI_AXIS_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
